// File: rtl/rf2p_stream_buf_pkg.sv
// Shared configuration for the 2-port RF streaming buffer: supported read
// latency, staging depth and the staging-entry layout.
package rf2p_stream_buf_pkg;

  localparam int RF_RD_LAT   = 1;
  localparam int STAGE_DEPTH = 2;
  localparam int STAGE_DWD   = 16;

  typedef struct packed {
    logic [STAGE_DWD-1:0] data;
    logic                 vld;
  } rf_stage_t;

endpackage

// File: rtl/rf2p_skid_stage.sv
// Two-entry in-order staging buffer fed by RF read data; entry 0 is the head
// and keeps its data when it drains so the consumer data holds its last value.
module rf2p_skid_stage
  import rf2p_stream_buf_pkg::*;
#(
  parameter int DWD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           capture,
  input  logic [DWD-1:0] cap_data,
  input  logic           pop,
  output logic [1:0]     stage_cnt,
  output logic [DWD-1:0] head_data
);

  typedef struct packed {
    logic [DWD-1:0] data;
    logic           vld;
  } stage_ent_t;

  stage_ent_t ent0, ent1;

  assign stage_cnt = 2'(ent0.vld) + 2'(ent1.vld);
  assign head_data = ent0.data;

  // Entry 1 is only ever valid while entry 0 is valid; a pop shifts it forward.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (!ent0.vld) ent0 <= '{data: cap_data, vld: 1'b1};
          else           ent1 <= '{data: cap_data, vld: 1'b1};
        end
        2'b01: begin
          if (ent1.vld) begin
            ent0     <= ent1;
            ent1.vld <= 1'b0;
          end else begin
            ent0.vld <= 1'b0;
          end
        end
        2'b11: begin
          if (ent1.vld) begin
            ent0      <= ent1;
            ent1.data <= cap_data;
          end else begin
            ent0.data <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf2p_stream_buf.sv
// Streaming FIFO controller around a 2-port register file with 1-cycle reads.
// Optional high-water-mark output o_hwm is built when RF2PBUF_HWM_EN is defined.
module rf2p_stream_buf
  import rf2p_stream_buf_pkg::*;
#(
  parameter int DWD    = 16,
  parameter int AWD    = 5,
  parameter int RD_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [DWD-1:0] i_data,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [DWD-1:0] o_data,
  output logic [AWD+1:0] o_count,
  output logic           o_rf_write,
  output logic [AWD-1:0] o_rf_waddr,
  output logic [DWD-1:0] o_rf_wdata,
  output logic           o_rf_read,
  output logic [AWD-1:0] o_rf_raddr,
`ifdef RF2PBUF_HWM_EN
  output logic [AWD+1:0] o_hwm,
`endif
  input  logic [DWD-1:0] i_rf_rdata
);

  localparam int         DEPTH   = 2**AWD;
  localparam logic [AWD:0] DEPTH_C = (AWD+1)'(DEPTH);

  if (RD_LAT != RF_RD_LAT) begin : g_bad_rd_lat
    $error("rf2p_stream_buf: RD_LAT=%0d unsupported, only %0d", RD_LAT, RF_RD_LAT);
  end

  typedef struct packed {
    logic           write;
    logic [AWD-1:0] waddr;
    logic [DWD-1:0] wdata;
    logic           read;
    logic [AWD-1:0] raddr;
  } rf_bus_t;

  rf_bus_t        rf;
  logic [AWD-1:0] wptr, rptr;
  logic [AWD:0]   rf_cnt;
  logic           inflight;
  logic [1:0]     stage_cnt;
  logic [2:0]     stage_occ;
  logic [AWD+1:0] count_q;
  logic           push, pop, rd, flush;

  // Both streams transfer on a cycle where valid and ready are high together;
  // o_ready and o_valid depend only on registered state, never on the partner.
  assign flush   = i_rst | i_clear;
  assign o_ready = (rf_cnt < DEPTH_C);
  assign push    = i_valid & o_ready;
  assign o_valid = (stage_cnt != 2'd0);
  assign pop     = o_valid & i_ready;

  // Staging credit counts the same-cycle pop so a full pipe still streams
  // one word per cycle; rf_cnt is the pre-push value, so no read-during-write.
  assign stage_occ = 3'(stage_cnt) + 3'(inflight);
  assign rd = (rf_cnt != '0) && (stage_occ < (3'(STAGE_DEPTH) + 3'(pop))) && !i_clear;

  always_comb begin
    rf.write = push;
    rf.waddr = wptr;
    rf.wdata = push ? i_data : '0;
    rf.read  = rd;
    rf.raddr = rptr;
  end

  assign o_rf_write = rf.write;
  assign o_rf_waddr = rf.waddr;
  assign o_rf_wdata = rf.wdata;
  assign o_rf_read  = rf.read;
  assign o_rf_raddr = rf.raddr;
  assign o_count    = count_q;

  always_ff @(posedge i_clk) begin
    if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      rf_cnt   <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (rd)   rptr <= rptr + 1'b1;
      rf_cnt   <= rf_cnt + (AWD+1)'(push) - (AWD+1)'(rd);
      inflight <= rd;
      count_q  <= count_q + (AWD+2)'(push) - (AWD+2)'(pop);
    end
  end

  rf2p_skid_stage #(.DWD(DWD)) u_stage (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (i_clear),
    .capture   (inflight),
    .cap_data  (i_rf_rdata),
    .pop       (pop),
    .stage_cnt (stage_cnt),
    .head_data (o_data)
  );

`ifdef RF2PBUF_HWM_EN
  always_ff @(posedge i_clk) begin
    if (flush)                o_hwm <= '0;
    else if (count_q > o_hwm) o_hwm <= count_q;
  end
`endif

endmodule

// File: tb/tb_rf2p_stream_buf.sv
// Directed + randomized bench for rf2p_stream_buf with a behavioural RF and a
// queue-based reference of the stream contents and occupancy.
module tb_rf2p_stream_buf;

  logic        clk = 1'b0;
  logic        i_rst, i_clear, i_valid, i_ready;
  logic [15:0] i_data, i_rf_rdata;
  logic        o_ready, o_valid, o_rf_write, o_rf_read;
  logic [15:0] o_data, o_rf_wdata;
  logic [6:0]  o_count;
  logic [4:0]  o_rf_waddr, o_rf_raddr;
`ifdef RF2PBUF_HWM_EN
  logic [6:0]  o_hwm;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  int          cnt_m = 0;
  logic [4:0]  wptr_m = '0;
  bit          chk_en = 1'b0;
  logic [15:0] mem [32];

  always #5 clk = ~clk;

  rf2p_stream_buf dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_clear    (i_clear),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_rf_write (o_rf_write),
    .o_rf_waddr (o_rf_waddr),
    .o_rf_wdata (o_rf_wdata),
    .o_rf_read  (o_rf_read),
    .o_rf_raddr (o_rf_raddr),
`ifdef RF2PBUF_HWM_EN
    .o_hwm      (o_hwm),
`endif
    .i_rf_rdata (i_rf_rdata)
  );

  // Register-file macro: 1-cycle read, junk on the data bus when not read.
  always @(posedge clk) begin
    if (o_rf_write) mem[o_rf_waddr] <= o_rf_wdata;
    i_rf_rdata <= o_rf_read ? mem[o_rf_raddr] : 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r,
                     input logic clr, input logic rst);
    bit pushed, popped;
    @(negedge clk);
    i_valid = v; i_data = d; i_ready = r; i_clear = clr; i_rst = rst;
    #1;
    pushed = v && (o_ready === 1'b1);
    popped = (o_valid === 1'b1) && r;
    if (chk_en) begin
      check("count", 32'(o_count), 32'(cnt_m));
      if (cnt_m == 0)  check("valid_when_empty", 32'(o_valid), 32'd0);
      if (cnt_m < 32)  check("ready_with_room", 32'(o_ready), 32'd1);
      if (cnt_m >= 34) check("ready_when_full", 32'(o_ready), 32'd0);
      check("wr_en", 32'(o_rf_write), 32'(pushed));
      if (pushed) check("waddr", 32'(o_rf_waddr), 32'(wptr_m));
      if (pushed) check("wdata", 32'(o_rf_wdata), 32'(d));
      if (o_rf_write && o_rf_read) check("rw_same_addr", 32'(o_rf_raddr != o_rf_waddr), 32'd1);
      if (popped && !clr && !rst) begin
        if (exp_q.size() == 0) check("pop_nonempty", 32'(exp_q.size()), 32'd1);
        else                   check("o_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    if (clr || rst) begin
      exp_q.delete();
      cnt_m  = 0;
      wptr_m = '0;
    end else begin
      if (pushed) begin
        exp_q.push_back(d);
        cnt_m++;
        wptr_m++;
      end
      if (popped) cnt_m--;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_write", 32'(o_rf_write), 32'd0);
    check("rst_read", 32'(o_rf_read), 32'd0);
    check("rst_waddr", 32'(o_rf_waddr), 32'd0);
    check("rst_raddr", 32'(o_rf_raddr), 32'd0);
    check("rst_wdata", 32'(o_rf_wdata), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
`ifdef RF2PBUF_HWM_EN
    check("rst_hwm", 32'(o_hwm), 32'd0);
`endif
  endtask

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;

    // Reset
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 1);
    chk_en = 1'b1;
    cyc(0, 16'h0, 0, 0, 0);
    check_reset_vals();

    // Single word: write in cycle 0, read in 1, valid in 3
    cyc(1, 16'h00A5, 0, 0, 0);
    check("t1_write", 32'(o_rf_write), 32'd1);
    check("t1_waddr", 32'(o_rf_waddr), 32'd0);
    cyc(0, 16'h0, 0, 0, 0);
    check("t1_read", 32'(o_rf_read), 32'd1);
    check("t1_raddr", 32'(o_rf_raddr), 32'd0);
    cyc(0, 16'h0, 0, 0, 0);
    check("t1_valid_c2", 32'(o_valid), 32'd0);
    cyc(0, 16'h0, 1, 0, 0);
    check("t1_valid_c3", 32'(o_valid), 32'd1);
    cyc(0, 16'h0, 0, 0, 0);
    check("t1_valid_after_pop", 32'(o_valid), 32'd0);

    // Streaming 0..99, one word per cycle out from cycle 3
    for (int k = 0; k < 100; k++) begin
      cyc(1, 16'(k), 1, 0, 0);
      if (k >= 3) check("stream_valid", 32'(o_valid), 32'd1);
      check("stream_count_le3", 32'(o_count <= 7'd3), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, 16'h0, 1, 0, 0);
      check("stream_tail_valid", 32'(o_valid), 32'd1);
    end
    cyc(0, 16'h0, 1, 0, 0);

    // Full and wrap: 34 of 40 accepted, a pop does not raise o_ready
    for (int k = 0; k < 40; k++) cyc(1, 16'($urandom), 0, 0, 0);
    check("full_accepted", 32'(exp_q.size()), 32'd34);
    cyc(1, 16'hBEEF, 1, 0, 0);
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_no_write", 32'(o_rf_write), 32'd0);
    for (int k = 0; k < 40; k++) cyc(0, 16'h0, 1, 0, 0);
    check("full_drained", 32'(exp_q.size()), 32'd0);

    // Random backpressure
    for (int k = 0; k < 300; k++)
      cyc(1'($urandom_range(0, 9) < 8), 16'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    for (int k = 0; k < 40; k++) cyc(0, 16'h0, 1, 0, 0);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Clear with 10 entries, a read in flight and a concurrent push
    for (int k = 0; k < 11; k++) cyc(1, 16'(16'h0100 + k), 0, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    check("pop_credit_read", 32'(o_rf_read), 32'd1);
    cyc(1, 16'hDEAD, 0, 1, 0);
    check("clear_blocks_read", 32'(o_rf_read), 32'd0);
    cyc(0, 16'h0, 0, 0, 0);
    check("clear_ready", 32'(o_ready), 32'd1);
    check("clear_valid", 32'(o_valid), 32'd0);
    cyc(1, 16'h1234, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    check("clear_no_stale", 32'(o_valid), 32'd0);
    cyc(0, 16'h0, 1, 0, 0);
    check("clear_first_data", 32'(o_data), 32'h1234);
    cyc(0, 16'h0, 0, 0, 0);

    // Reset with a full buffer
    for (int k = 0; k < 36; k++) cyc(1, 16'($urandom), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
`ifdef RF2PBUF_HWM_EN
    check("hwm_full", 32'(o_hwm), 32'd34);
`endif
    cyc(1, 16'h5A5A, 1, 0, 1);
    cyc(0, 16'h0, 0, 0, 0);
    check_reset_vals();

    cyc(0, 16'h0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
